// File: rtl/clk_div_ctrl.sv
// Run/stop sequencer and glitch-free reconfiguration controller for a toggle-style clock divider.
// Optional completed-period counter is built when CLK_DIV_CTRL_PERIOD_CNT_EN is defined.
module clk_div_ctrl #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 4,
  parameter int MIN_DIV     = 1
) (
  input  logic             inClk,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             outClk,
  output logic             edgeTick,
  output logic             busy,
  output logic [15:0]      periodCnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DEFAULT_DIV_W = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV_W     = WIDTH'(MIN_DIV);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             out_clk_q, out_clk_d;
  logic             edge_tick_q, edge_tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_accept;
  logic             cfg_legal;
  logic             at_limit;
  logic             fall_tick;

  // IDLE always accepts; while running, the single pending slot throttles the source.
  assign cfg_ready  = (state_q == ST_IDLE) || !pend_valid_q;
  assign cfg_accept = cfg_valid && cfg_ready;
  assign cfg_legal  = (cfg_div >= MIN_DIV_W);
  assign at_limit   = (count_q == div_q);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    div_d        = div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    out_clk_d    = out_clk_q;
    edge_tick_d  = 1'b0;
    fall_tick    = 1'b0;
    cfg_err_d    = cfg_err_q | (cfg_accept & ~cfg_legal);

    case (state_q)
      ST_IDLE: begin
        count_d   = '0;
        out_clk_d = 1'b0;
        // A value parked while stopping is applied here; a fresh legal offer overrides it.
        if (pend_valid_q) begin
          div_d        = pend_div_q;
          pend_valid_d = 1'b0;
        end
        if (cfg_accept && cfg_legal) begin
          div_d = cfg_div;
        end
        if (run) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!run && !out_clk_q) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (at_limit) begin
          count_d     = '0;
          out_clk_d   = ~out_clk_q;
          edge_tick_d = 1'b1;
          if (out_clk_q) begin
            fall_tick = 1'b1;
            if (pend_valid_q) begin
              div_d        = pend_div_q;
              pend_valid_d = 1'b0;
            end
            if (!run) begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          count_d = count_q + WIDTH'(1);
          if (!run) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        // outClk is high here; finish the phase and fall cleanly.
        if (at_limit) begin
          count_d     = '0;
          out_clk_d   = 1'b0;
          edge_tick_d = 1'b1;
          fall_tick   = 1'b1;
          state_d     = ST_IDLE;
          if (pend_valid_q) begin
            div_d        = pend_div_q;
            pend_valid_d = 1'b0;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        count_d   = '0;
        out_clk_d = 1'b0;
      end
    endcase

    // Parked after any apply above, so a same-cycle offer waits for the next falling toggle.
    if ((state_q != ST_IDLE) && cfg_accept && cfg_legal) begin
      pend_valid_d = 1'b1;
      pend_div_d   = cfg_div;
    end
  end

  always_ff @(posedge inClk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      div_q        <= DEFAULT_DIV_W;
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      out_clk_q    <= 1'b0;
      edge_tick_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      div_q        <= div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      out_clk_q    <= out_clk_d;
      edge_tick_q  <= edge_tick_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign outClk   = out_clk_q;
  assign edgeTick = edge_tick_q;
  assign cfg_err  = cfg_err_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] period_cnt_q, period_cnt_d;

  always_comb begin
    period_cnt_d = period_cnt_q;
    if (fall_tick) begin
      period_cnt_d = period_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge inClk) begin
    if (reset) begin
      period_cnt_q <= '0;
    end else begin
      period_cnt_q <= period_cnt_d;
    end
  end

  assign periodCnt = period_cnt_q;
`else
  logic period_unused;
  assign period_unused = fall_tick;
  assign periodCnt     = '0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: vector table, directed corner sequences and random traffic vs a reference model.
module tb_clk_div_ctrl;
  localparam int WIDTH = 4;
  localparam int DEF   = 4;
  localparam int MIN   = 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2;

  logic             clk = 1'b0;
  logic             reset, run, cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready, cfg_err, outClk, edgeTick, busy;
  logic [15:0]      periodCnt;

  always #5 clk = ~clk;

  clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF), .MIN_DIV(MIN)) dut (
    .inClk(clk), .reset(reset), .run(run), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .outClk(outClk), .edgeTick(edgeTick),
    .busy(busy), .periodCnt(periodCnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase position, current half-period, queue of parked values.
  int m_st = M_IDLE;
  int m_el = 0;
  int m_div = DEF;
  int m_pend[$];
  bit m_out = 0, m_tick = 0, m_err = 0;
  int m_pc = 0;

  function automatic bit m_ready();
    return (m_st == M_IDLE) || (m_pend.size() == 0);
  endfunction

  task automatic model_step(input bit r, input bit rn, input bit v, input int d);
    bit acc, legal, fall;
    if (r) begin
      m_st = M_IDLE; m_el = 0; m_div = DEF; m_pend.delete();
      m_out = 0; m_tick = 0; m_err = 0; m_pc = 0;
      return;
    end
    acc = v && m_ready();
    legal = (d >= MIN);
    m_tick = 0;
    if (acc && !legal) m_err = 1;
    if (m_st == M_IDLE) begin
      if (m_pend.size() > 0) m_div = m_pend.pop_front();
      if (acc && legal) m_div = d;
      m_el = 0; m_out = 0;
      if (rn) m_st = M_RUN;
    end else begin
      if (m_st == M_RUN && !rn && !m_out) begin
        m_st = M_IDLE; m_el = 0;
      end else if (m_el == m_div) begin
        fall = m_out;
        m_out = !m_out; m_tick = 1; m_el = 0;
        if (fall) begin
          if (m_pend.size() > 0) m_div = m_pend.pop_front();
          m_pc = (m_pc + 1) % 65536;
          if (m_st == M_STOP || !rn) m_st = M_IDLE;
        end
      end else begin
        m_el++;
        if (m_st == M_RUN && !rn) m_st = M_STOP;
      end
      if (acc && legal) m_pend.push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    logic [20:0] act, exp;
    logic [15:0] exp_pc;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    exp_pc = 16'(m_pc);
`else
    exp_pc = 16'd0;
`endif
    act = {outClk, edgeTick, cfg_ready, busy, cfg_err, periodCnt};
    exp = {m_out, m_tick, m_ready(), (m_st != M_IDLE), m_err, exp_pc};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL model[%s] out/tick/rdy/busy/err/pc got %b %b %b %b %b %h, expected %b %b %b %b %b %h",
               tag, act[20], act[19], act[18], act[17], act[16], act[15:0],
               exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit rn, input bit v, input int d, input string tag);
    @(negedge clk);
    reset = r; run = rn; cfg_valid = v; cfg_div = WIDTH'(d);
    @(posedge clk);
    model_step(r, rn, v, d);
    #1;
    check_model(tag);
    $display("cyc rst=%0b run=%0b v=%0b d=%0d -> out=%0b tick=%0b rdy=%0b busy=%0b err=%0b pc=%0d [%s]",
             r, rn, v, d, outClk, edgeTick, cfg_ready, busy, cfg_err, periodCnt, tag);
  endtask

  task automatic run_until_tick(input bit rn, input int max, output int n);
    n = 0;
    do begin
      cycle(0, rn, 0, 0, "wait_tick");
      n++;
    end while (!edgeTick && n < max);
    vectors++;
    if (!edgeTick) begin
      miscompares++;
      $display("FAIL tick_timeout: got no edgeTick in %0d cycles, expected one", max);
    end
  endtask

  typedef struct {
    bit r, rn, v;
    int d;
    bit e_out, e_tick, e_ready, e_busy, e_err;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int n;
    reset = 1; run = 0; cfg_valid = 0; cfg_div = '0;

    //          r  rn v  d   out tick rdy busy err
    tbl[0]  = '{1, 0, 0, 0,  0,  0,   1,  0,   0};
    tbl[1]  = '{0, 1, 0, 0,  0,  0,   1,  1,   0};
    tbl[2]  = '{0, 1, 0, 0,  0,  0,   1,  1,   0};
    tbl[3]  = '{0, 1, 0, 0,  0,  0,   1,  1,   0};
    tbl[4]  = '{0, 1, 0, 0,  0,  0,   1,  1,   0};
    tbl[5]  = '{0, 1, 0, 0,  0,  0,   1,  1,   0};
    tbl[6]  = '{0, 1, 0, 0,  1,  1,   1,  1,   0};
    tbl[7]  = '{0, 1, 1, 0,  1,  0,   1,  1,   1};
    tbl[8]  = '{0, 1, 0, 0,  1,  0,   1,  1,   1};
    tbl[9]  = '{0, 1, 0, 0,  1,  0,   1,  1,   1};
    tbl[10] = '{0, 1, 0, 0,  1,  0,   1,  1,   1};
    tbl[11] = '{0, 1, 0, 0,  0,  1,   1,  1,   1};
    tbl[12] = '{0, 1, 0, 0,  0,  0,   1,  1,   1};
    tbl[13] = '{0, 1, 0, 0,  0,  0,   1,  1,   1};
    tbl[14] = '{0, 1, 0, 0,  0,  0,   1,  1,   1};
    tbl[15] = '{0, 1, 0, 0,  0,  0,   1,  1,   1};
    tbl[16] = '{0, 1, 0, 0,  1,  1,   1,  1,   1};

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].r, tbl[i].rn, tbl[i].v, tbl[i].d, "table");
      vectors++;
      if ({outClk, edgeTick, cfg_ready, busy, cfg_err} !==
          {tbl[i].e_out, tbl[i].e_tick, tbl[i].e_ready, tbl[i].e_busy, tbl[i].e_err}) begin
        miscompares++;
        $display("FAIL table[%0d] out/tick/rdy/busy/err got %b%b%b%b%b, expected %b%b%b%b%b", i,
                 outClk, edgeTick, cfg_ready, busy, cfg_err, tbl[i].e_out, tbl[i].e_tick,
                 tbl[i].e_ready, tbl[i].e_busy, tbl[i].e_err);
      end
    end

    // Reconfigure to div=2 during a high phase.
    cycle(1, 0, 0, 0, "reset");
    run_until_tick(1, 20, n);  check_eq("first_rise_latency", n, 6);
    cycle(0, 1, 1, 2, "offer_div2");
    check_eq("ready_low_while_pending", cfg_ready, 0);
    run_until_tick(1, 20, n);  check_eq("old_high_phase_rest", n, 4);
    check_eq("fall_after_reconfig", outClk, 0);
    check_eq("ready_after_apply", cfg_ready, 1);
    run_until_tick(1, 20, n);  check_eq("new_low_phase", n, 3);
    run_until_tick(1, 20, n);  check_eq("new_high_phase", n, 3);

    // Stop two cycles into a high phase, then stop during a low phase.
    cycle(1, 0, 0, 0, "reset");
    run_until_tick(1, 20, n);  check_eq("rise_before_stop", n, 6);
    cycle(0, 1, 0, 0, "high1");
    cycle(0, 1, 0, 0, "high2");
    cycle(0, 0, 0, 0, "drop_run_high");
    check_eq("stop_busy", busy, 1);
    check_eq("stop_out_high", outClk, 1);
    run_until_tick(0, 20, n);  check_eq("stop_fall_delay", n, 2);
    check_eq("stop_fall_out", outClk, 0);
    check_eq("stop_then_idle", busy, 0);
    run_until_tick(1, 20, n);  check_eq("restart_rise", n, 6);
    run_until_tick(1, 20, n);  check_eq("restart_fall", n, 5);
    cycle(0, 1, 0, 0, "low1");
    cycle(0, 0, 0, 0, "drop_run_low");
    check_eq("low_stop_idle", busy, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, "idle_hold");
      check_eq("idle_out_low", outClk, 0);
    end

    // Reset in mid-high phase with a pending value and a sticky error.
    cycle(1, 0, 0, 0, "reset");
    cycle(0, 0, 1, 0, "offer_zero_idle");
    check_eq("err_set_idle", cfg_err, 1);
    run_until_tick(1, 20, n);  check_eq("rise_div4", n, 6);
    cycle(0, 1, 1, 2, "park_div2");
    cycle(0, 1, 0, 0, "high2");
    cycle(1, 1, 0, 0, "mid_reset");
    check_eq("reset_out", outClk, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_err", cfg_err, 0);
    check_eq("reset_ready", cfg_ready, 1);
    run_until_tick(1, 20, n);  check_eq("post_reset_rise", n, 6);
    run_until_tick(1, 20, n);  check_eq("post_reset_div4", n, 5);

    // Largest divide value: half-period of 16 cycles.
    cycle(1, 0, 0, 0, "reset");
    cycle(0, 0, 1, 15, "load_div15");
    run_until_tick(1, 40, n);  check_eq("div15_first_rise", n, 17);
    run_until_tick(1, 40, n);  check_eq("div15_half_period", n, 16);

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    cycle(1, 0, 0, 0, "reset");
    for (int i = 0; i < 14; i++) run_until_tick(1, 20, n);
    check_eq("period_cnt_7", periodCnt, 7);
    @(negedge clk);
    force dut.period_cnt_q = 16'hFFFF;
    #1;
    release dut.period_cnt_q;
    m_pc = 16'hFFFF;
    run_until_tick(1, 20, n);
    run_until_tick(1, 20, n);
    check_eq("period_cnt_wrap", periodCnt, 0);
`endif

    // Random traffic against the model.
    cycle(1, 0, 0, 0, "reset");
    begin
      bit rn_r = 0;
      for (int i = 0; i < 3000; i++) begin
        bit r_r, v_r;
        int d_r;
        r_r = ($urandom_range(0, 249) == 0);
        if ($urandom_range(0, 29) == 0) rn_r = !rn_r;
        v_r = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 5))
          0:       d_r = 0;
          1:       d_r = 15;
          default: d_r = $urandom_range(0, 5);
        endcase
        cycle(r_r, rn_r, v_r, d_r, "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run/stop sequencer and reconfiguration controller for the team's toggle-style clock divider datapath.
- Owns the divide value and produces `outClk` plus a one-cycle edge tick.
- Accepts new divide values over a valid/ready handshake and applies them only at period boundaries, so `outClk` never produces a runt phase.
- Sits between the lab control logic (run switch, configuration source) and the clocked logic that consumes `outClk` / `edgeTick`.

Parameters:
- WIDTH, 4: width of the divide value and phase counter.
- DEFAULT_DIV, 4: divide value loaded at reset. Half-period = DEFAULT_DIV+1 `inClk` cycles.
- MIN_DIV, 1: smallest legal `cfg_div`. Smaller values are rejected.

Ports:
- inClk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  level; 1 = divider running, 0 = request orderly stop.
- cfg_valid  input  1  configuration request valid.
- cfg_div  input  WIDTH  requested divide value; half-period = cfg_div+1 cycles.
- cfg_ready  output  1  controller can accept a configuration this cycle.
- cfg_err  output  1  sticky: a value below MIN_DIV was offered; cleared by reset only.
- outClk  output  1  divided clock.
- edgeTick  output  1  one-cycle pulse in the cycle `outClk` toggles (registered alongside it).
- busy  output  1  1 when state is not IDLE.
- periodCnt  output  16  completed full periods (see Optional Feature).

Behaviour:
- Reset (sampled on posedge `inClk` when reset=1):
  - state=IDLE, count=0, div=DEFAULT_DIV, pending empty.
  - outClk=0, edgeTick=0, cfg_err=0, periodCnt=0.
  - cfg_ready=1 in the first cycle after reset.
- Reset mid-operation: abandons the current phase and any pending config immediately.
- Handshake: a transfer occurs when cfg_valid=1 and cfg_ready=1 on the same edge.
  - cfg_div < MIN_DIV: transfer still completes, cfg_err is set, value is discarded.
- IDLE:
  - outClk=0, count=0, cfg_ready=1.
  - An accepted legal value loads `div` directly.
  - run=1 -> RUN on the next edge, count starts at 0.
- RUN:
  - count increments each cycle.
  - When count==div: count<=0, outClk<=~outClk, edgeTick=1.
  - First rising edge of outClk occurs div+1 cycles after entering RUN. Period = 2*(div+1) cycles.
- Reconfiguration in RUN:
  - cfg_ready=1 only while the pending slot is empty.
  - An accepted legal value goes to pending.
  - Pending is applied at the next falling toggle (outClk 1->0): div<=pending in the same edge that clears count, and the slot empties.
  - A value accepted in the same cycle as a falling toggle waits for the following falling toggle.
- run=0 in RUN:
  - If outClk=0: -> IDLE next edge, count cleared, no toggle.
  - If outClk=1: -> STOP.
- STOP:
  - Counting continues until count==div; the falling toggle is produced with edgeTick=1, then -> IDLE.
  - A pending value is applied at that falling toggle.
  - run re-asserted in STOP is ignored until IDLE is reached; if still 1 in IDLE, RUN re-enters on the next edge.
- Wrap-around:
  - count never exceeds div.
  - div = 2^WIDTH-1 is legal (half-period 2^WIDTH cycles).
  - periodCnt wraps 0xFFFF -> 0.
- busy=1 in RUN and STOP.

Optional Feature:
- Macro: CLK_DIV_CTRL_PERIOD_CNT_EN.
- Defined: periodCnt increments on every falling toggle of outClk, including the STOP-state falling toggle. It is cleared by reset only and holds in IDLE.
- Undefined: the counter logic is not built and periodCnt is tied to 0.

Test Plan:
- Reset, run=1, no cfg -> outClk first rises 5 cycles after RUN entry, then toggles every 5 cycles (period 10); edgeTick pulses coincide with each toggle.
- In RUN with outClk=1, offer cfg_div=2 -> accepted; current high phase still lasts 5 cycles; after the falling toggle, phases are 3 cycles; cfg_ready low from accept until apply.
- Offer cfg_div=0 with MIN_DIV=1 -> handshake completes, cfg_err=1 and stays 1; div unchanged (period still 10).
- Drop run 2 cycles into a high phase -> STOP; outClk falls 3 cycles later with edgeTick=1, then IDLE, busy=0; drop run during a low phase -> IDLE next edge, outClk stays 0.
- Assert reset mid-high-phase with a pending cfg -> next cycle outClk=0, IDLE, div=4, pending discarded, cfg_err=0.
- With CLK_DIV_CTRL_PERIOD_CNT_EN defined: run 7 full periods -> periodCnt=7; preload the counter near wrap via a force -> 0xFFFF wraps to 0.
